// File: rtl/davos_pkg.sv
// Shared mem-command definitions: field widths and the splitter FSM state type.
package davos_pkg;
  localparam int MEM_ADDR_W = 64;
  localparam int MEM_LEN_W  = 32;

  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} split_state_e;

  function automatic logic [MEM_LEN_W:0] min33(input logic [MEM_LEN_W:0] a,
                                               input logic [MEM_LEN_W:0] b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/mem_cmd_rr_splitter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester above last_grant, wrapping around.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] request_i,
  input  logic [CH_W-1:0]   last_grant_i,
  output logic [NUM_CH-1:0] grant_o
);
  logic found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      automatic int idx = (int'(last_grant_i) + k) % NUM_CH;
      if (!found && request_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_cmd_rr_splitter.sv
// Arbitrates NUM_CH mem-command channels round-robin and splits each accepted
// command into MAX_LEN-aligned chunks, one chunk per cycle under continuous ready.
module mem_cmd_rr_splitter
  import davos_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int MAX_LEN = 4096,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NUM_CH-1:0]           s_cmd_valid,
  output logic [NUM_CH-1:0]           s_cmd_ready,
  input  logic [NUM_CH*MEM_ADDR_W-1:0] s_cmd_address,
  input  logic [NUM_CH*MEM_LEN_W-1:0]  s_cmd_length,
  output logic                        m_cmd_valid,
  input  logic                        m_cmd_ready,
  output logic [MEM_ADDR_W-1:0]       m_cmd_address,
  output logic [MEM_LEN_W-1:0]        m_cmd_length,
  output logic [CH_W-1:0]             m_cmd_dest,
  output logic                        m_cmd_last
);
  localparam logic [MEM_LEN_W:0]    MAX33    = (MEM_LEN_W+1)'(MAX_LEN);
  localparam logic [MEM_ADDR_W-1:0] OFF_MASK = MEM_ADDR_W'(MAX_LEN - 1);

  split_state_e          state_q, state_d;
  logic [CH_W-1:0]       last_grant_q, last_grant_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [MEM_LEN_W:0]    rem_q, rem_d;
  logic                  mvalid_q, mvalid_d;
  logic [MEM_ADDR_W-1:0] maddr_q, maddr_d;
  logic [MEM_LEN_W-1:0]  mlen_q, mlen_d;
  logic [CH_W-1:0]       mdest_q, mdest_d;
  logic                  mlast_q, mlast_d;

  logic [NUM_CH-1:0]     grant;
  logic [CH_W-1:0]       gidx;
  logic [MEM_ADDR_W-1:0] sel_addr, sel_off;
  logic [MEM_LEN_W-1:0]  sel_len;
  logic [MEM_LEN_W:0]    first_chunk, next_chunk;
  logic                  accept;

  rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .request_i    (s_cmd_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign s_cmd_ready = (aresetn && state_q == IDLE) ? grant : '0;
  assign accept      = |s_cmd_ready;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (grant[i]) gidx = CH_W'(i);
  end

  assign sel_addr = s_cmd_address[MEM_ADDR_W*int'(gidx) +: MEM_ADDR_W];
  assign sel_len  = s_cmd_length[MEM_LEN_W*int'(gidx) +: MEM_LEN_W];
  assign sel_off  = sel_addr & OFF_MASK;
  // First chunk stops at the next aligned boundary; later chunks start aligned.
  assign first_chunk = min33({1'b0, sel_len}, MAX33 - (MEM_LEN_W+1)'(sel_off));
  assign next_chunk  = min33(rem_q, MAX33);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    mvalid_d     = mvalid_q;
    maddr_d      = maddr_q;
    mlen_d       = mlen_q;
    mdest_d      = mdest_q;
    mlast_d      = mlast_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          last_grant_d = gidx;
          if (sel_len != '0) begin
            state_d  = SPLIT;
            mvalid_d = 1'b1;
            maddr_d  = sel_addr;
            mlen_d   = first_chunk[MEM_LEN_W-1:0];
            mdest_d  = gidx;
            mlast_d  = (first_chunk == {1'b0, sel_len});
            addr_d   = sel_addr + MEM_ADDR_W'(first_chunk);
            rem_d    = {1'b0, sel_len} - first_chunk;
          end
        end
      end
      SPLIT: begin
        if (mvalid_q && m_cmd_ready) begin
          if (mlast_q) begin
            state_d  = IDLE;
            mvalid_d = 1'b0;
          end else begin
            maddr_d = addr_q;
            mlen_d  = next_chunk[MEM_LEN_W-1:0];
            mlast_d = (next_chunk == rem_q);
            addr_d  = addr_q + MEM_ADDR_W'(next_chunk);
            rem_d   = rem_q - next_chunk;
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      last_grant_q <= CH_W'(NUM_CH - 1);
      addr_q       <= '0;
      rem_q        <= '0;
      mvalid_q     <= 1'b0;
      maddr_q      <= '0;
      mlen_q       <= '0;
      mdest_q      <= '0;
      mlast_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      mvalid_q     <= mvalid_d;
      maddr_q      <= maddr_d;
      mlen_q       <= mlen_d;
      mdest_q      <= mdest_d;
      mlast_q      <= mlast_d;
    end
  end

  assign m_cmd_valid   = mvalid_q;
  assign m_cmd_address = maddr_q;
  assign m_cmd_length  = mlen_q;
  assign m_cmd_dest    = mdest_q;
  assign m_cmd_last    = mlast_q;
endmodule

// File: tb/tb_mem_cmd_rr_splitter.sv
// Scoreboard bench for mem_cmd_rr_splitter: expected chunks queued at stimulus, checked at handshake.
module tb_mem_cmd_rr_splitter;
  localparam int NUM_CH = 4;
  localparam int MAX_LEN = 4096;
  localparam int CH_W = 2;

  logic                 aclk = 1'b0;
  logic                 aresetn = 1'b0;
  logic [NUM_CH-1:0]    s_cmd_valid = '0;
  logic [NUM_CH-1:0]    s_cmd_ready;
  logic [NUM_CH*64-1:0] s_cmd_address = '0;
  logic [NUM_CH*32-1:0] s_cmd_length = '0;
  logic                 m_cmd_valid;
  logic                 m_cmd_ready = 1'b1;
  logic [63:0]          m_cmd_address;
  logic [31:0]          m_cmd_length;
  logic [CH_W-1:0]      m_cmd_dest;
  logic                 m_cmd_last;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [63:0]     a;
    logic [31:0]     l;
    logic [CH_W-1:0] d;
    logic            last;
  } exp_t;
  exp_t sb[$];

  mem_cmd_rr_splitter #(.NUM_CH(NUM_CH), .MAX_LEN(MAX_LEN), .CH_W(CH_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_cmd_address(s_cmd_address), .s_cmd_length(s_cmd_length),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_address(m_cmd_address), .m_cmd_length(m_cmd_length),
    .m_cmd_dest(m_cmd_dest), .m_cmd_last(m_cmd_last)
  );

  always #5 aclk = ~aclk;

  // Reference split: chunk size is the distance to the next MAX_LEN multiple, capped by what remains.
  task automatic push_cmd(input int ch, input logic [63:0] addr, input logic [31:0] len);
    logic [63:0] a = addr;
    logic [32:0] rem = {1'b0, len};
    logic [63:0] room;
    logic [32:0] c;
    while (rem != 0) begin
      room = 64'(MAX_LEN) - (a % 64'(MAX_LEN));
      c = (64'(rem) < room) ? rem : room[32:0];
      sb.push_back('{a: a, l: c[31:0], d: CH_W'(ch), last: (c == rem)});
      a = a + 64'(c);
      rem = rem - c;
    end
  endtask

  always @(negedge aclk) begin
    if (aresetn && m_cmd_valid && m_cmd_ready) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL chunk_unexpected: got addr=%h len=%h dest=%0d last=%0b, required none",
                 m_cmd_address, m_cmd_length, m_cmd_dest, m_cmd_last);
      end else begin
        automatic exp_t e = sb.pop_front();
        if (m_cmd_address !== e.a || m_cmd_length !== e.l || m_cmd_dest !== e.d || m_cmd_last !== e.last)
          $display("FAIL chunk: got addr=%h len=%h dest=%0d last=%0b, required addr=%h len=%h dest=%0d last=%0b",
                   m_cmd_address, m_cmd_length, m_cmd_dest, m_cmd_last, e.a, e.l, e.d, e.last);
        else passed++;
      end
    end
  end

  task automatic do_reset();
    @(posedge aclk); #1;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  task automatic send(input int ch, input logic [63:0] a, input logic [31:0] l, input bit do_push);
    bit got = 0;
    @(posedge aclk); #1;
    s_cmd_address[ch*64 +: 64] = a;
    s_cmd_length[ch*32 +: 32] = l;
    s_cmd_valid[ch] = 1'b1;
    if (do_push) push_cmd(ch, a, l);
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge aclk);
      if (s_cmd_ready[ch]) got = 1;
    end
    checks++;
    if (!got) $display("FAIL grant_timeout: ch=%0d never got ready, required ready", ch);
    else passed++;
    @(posedge aclk); #1;
    s_cmd_valid[ch] = 1'b0;
    if (got) begin
      checks++;
      if (m_cmd_valid !== (l != 0))
        $display("FAIL accept_latency: ch=%0d m_cmd_valid=%0b required %0b", ch, m_cmd_valid, (l != 0));
      else passed++;
    end
  endtask

  task automatic wait_drain(input string name);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge aclk);
      if (sb.size() == 0 && !m_cmd_valid) done = 1;
    end
    checks++;
    if (!done) $display("FAIL %s_drain: %0d chunks outstanding, valid=%0b, required 0", name, sb.size(), m_cmd_valid);
    else passed++;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s_cmd_valid = '1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks += 6;
    if (m_cmd_valid !== 1'b0) $display("FAIL rst_valid: got %0b required 0", m_cmd_valid); else passed++;
    if (m_cmd_address !== 64'h0) $display("FAIL rst_addr: got %h required 0", m_cmd_address); else passed++;
    if (m_cmd_length !== 32'h0) $display("FAIL rst_len: got %h required 0", m_cmd_length); else passed++;
    if (m_cmd_dest !== '0) $display("FAIL rst_dest: got %0d required 0", m_cmd_dest); else passed++;
    if (m_cmd_last !== 1'b0) $display("FAIL rst_last: got %0b required 0", m_cmd_last); else passed++;
    if (s_cmd_ready !== '0) $display("FAIL rst_ready: got %b required 0000", s_cmd_ready); else passed++;
    s_cmd_valid = '0;
    @(posedge aclk); #1 aresetn = 1'b1;
  endtask

  task automatic test_boundary_split();
    m_cmd_ready = 1'b1;
    send(0, 64'h1F00, 32'h300, 1);
    wait_drain("boundary");
  endtask

  task automatic test_three_chunks();
    send(1, 64'h0, 32'h2800, 1);
    wait_drain("three");
  endtask

  task automatic test_addr_wrap();
    send(3, 64'hFFFF_FFFF_FFFF_FF00, 32'h200, 1);
    wait_drain("wrap");
  endtask

  task automatic test_rr_order();
    int order[5] = '{0, 1, 2, 3, 0};
    int n = 0;
    int last_cyc = 0;
    do_reset();
    m_cmd_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      s_cmd_address[c*64 +: 64] = 64'(c * 64'h40);
      s_cmd_length[c*32 +: 32] = 32'h40;
    end
    for (int k = 0; k < 5; k++) push_cmd(order[k], 64'(order[k] * 64'h40), 32'h40);
    s_cmd_valid = '1;
    for (int cyc = 0; cyc < 100 && n < 5; cyc++) begin
      @(negedge aclk);
      if (s_cmd_ready != '0) begin
        checks++;
        if (s_cmd_ready !== 4'(1 << order[n]))
          $display("FAIL rr_grant%0d: ready=%b required %b", n, s_cmd_ready, 4'(1 << order[n]));
        else passed++;
        if (n > 0) begin
          checks++;
          if (cyc - last_cyc != 2) $display("FAIL rr_gap%0d: got %0d cycles required 2", n, cyc - last_cyc);
          else passed++;
        end
        last_cyc = cyc;
        n++;
      end
    end
    checks++;
    if (n != 5) $display("FAIL rr_count: got %0d grants required 5", n); else passed++;
    @(posedge aclk); #1 s_cmd_valid = '0;
    wait_drain("rr");
  endtask

  task automatic test_backpressure();
    m_cmd_ready = 1'b0;
    send(0, 64'h0, 32'h3000, 1);
    m_cmd_ready = 1'b1;
    @(posedge aclk); #1 m_cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      checks++;
      if (m_cmd_valid !== 1'b1 || m_cmd_address !== 64'h1000 || m_cmd_length !== 32'h1000 || m_cmd_last !== 1'b0)
        $display("FAIL bp_hold%0d: got v=%0b addr=%h len=%h last=%0b required v=1 addr=1000 len=1000 last=0",
                 i, m_cmd_valid, m_cmd_address, m_cmd_length, m_cmd_last);
      else passed++;
    end
    @(posedge aclk); #1 m_cmd_ready = 1'b1;
    wait_drain("bp");
  endtask

  task automatic test_zero_len();
    m_cmd_ready = 1'b1;
    send(1, 64'h700, 32'h0, 1);
    send(2, 64'h500, 32'h10, 1);
    wait_drain("zero");
  endtask

  task automatic test_reset_mid();
    m_cmd_ready = 1'b0;
    send(2, 64'h0, 32'h4000, 0);
    sb.push_back('{a: 64'h0, l: 32'h1000, d: 2'd2, last: 1'b0});
    m_cmd_ready = 1'b1;
    @(posedge aclk); #1 m_cmd_ready = 1'b0;
    checks++;
    if (m_cmd_valid !== 1'b1 || m_cmd_address !== 64'h1000)
      $display("FAIL rstmid_chunk2: got v=%0b addr=%h required v=1 addr=1000", m_cmd_valid, m_cmd_address);
    else passed++;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    checks++;
    if (m_cmd_valid !== 1'b0) $display("FAIL rstmid_valid: got %0b required 0", m_cmd_valid); else passed++;
    aresetn = 1'b1;
    m_cmd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      checks++;
      if (m_cmd_valid !== 1'b0) $display("FAIL rstmid_quiet%0d: got %0b required 0", i, m_cmd_valid);
      else passed++;
    end
    checks++;
    if (sb.size() != 0) $display("FAIL rstmid_sb: %0d chunks outstanding required 0", sb.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_boundary_split();
    test_three_chunks();
    test_addr_wrap();
    test_rr_order();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
